// File: rtl/lsu_mem_input.sv
// Purpose: LSU back end with a 2 KiB byte memory, a memory/peripheral address decoder and a switch-input register.
// Latency: decoder and load data are combinational; stores land 1 edge later; the switch register lags io_sw_i by 1 edge.
// Backpressure: none. Every store and load is accepted in the same cycle it is presented.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   st_en_i, addr_i      store enable and 12-bit byte address from the LSU
//   st_data_i, mask_i    store data and per-byte write mask (bit k -> byte k)
//   io_sw_i              raw switch inputs
//   addr_sel_o           region select {addr_i[11], addr_i[8]}
//   addr_memory_o        11-bit memory byte address (zero for peripheral accesses)
//   addr_periph_o        12-bit peripheral address (zero for memory accesses)
//   ld_data_o            32-bit little-endian memory read data
//   input_periph_data_o  registered switch value
module lsu_mem_input (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        st_en_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic [3:0]  mask_i,
    input  logic [31:0] io_sw_i,
    output logic [1:0]  addr_sel_o,
    output logic [10:0] addr_memory_o,
    output logic [11:0] addr_periph_o,
    output logic [31:0] ld_data_o,
    output logic [31:0] input_periph_data_o
);

    logic [7:0]       mem_q [0:2047];
    logic [31:0]      input_periph_data_q;
    logic [31:0]      input_periph_data_d;
    logic [10:0]      addr_mem;
    logic [3:0][10:0] byte_addr;
    logic             we;

    always_comb begin
        addr_sel_o    = {addr_i[11], addr_i[8]};
        addr_mem      = 11'h000;
        addr_periph_o = 12'h000;
        if (addr_i[11]) begin
            addr_periph_o = addr_i;
        end else begin
            addr_mem = addr_i[10:0];
        end
        addr_memory_o = addr_mem;

        // Byte lanes wrap inside the 11-bit space, so unaligned words
        // near 0x7FF spill over to 0x000.
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = addr_mem + 11'(k);
        end

        we                  = st_en_i & ~addr_i[11];
        input_periph_data_d = io_sw_i;

        ld_data_o = {mem_q[byte_addr[3]], mem_q[byte_addr[2]],
                     mem_q[byte_addr[1]], mem_q[byte_addr[0]]};
    end

    // Memory shares the reset block so writes are held off during reset,
    // but its contents are deliberately never cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            input_periph_data_q <= 32'h0000_0000;
        end else begin
            input_periph_data_q <= input_periph_data_d;
            if (we) begin
                for (int k = 0; k < 4; k++) begin
                    if (mask_i[k]) begin
                        mem_q[byte_addr[k]] <= st_data_i[8*k +: 8];
                    end
                end
            end
        end
    end

    assign input_periph_data_o = input_periph_data_q;

endmodule

// File: tb/tb_lsu_mem_input.sv
module tb_lsu_mem_input;

    logic        clk_i;
    logic        rst_ni;
    logic        st_en_i;
    logic [11:0] addr_i;
    logic [31:0] st_data_i;
    logic [3:0]  mask_i;
    logic [31:0] io_sw_i;
    logic [1:0]  addr_sel_o;
    logic [10:0] addr_memory_o;
    logic [11:0] addr_periph_o;
    logic [31:0] ld_data_o;
    logic [31:0] input_periph_data_o;

    int total = 0;
    int bad   = 0;

    // Reference model: plain byte array plus expected switch register.
    logic [7:0]  ref_mem [2048];
    logic [31:0] ref_sw;

    lsu_mem_input dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .st_en_i             (st_en_i),
        .addr_i              (addr_i),
        .st_data_i           (st_data_i),
        .mask_i              (mask_i),
        .io_sw_i             (io_sw_i),
        .addr_sel_o          (addr_sel_o),
        .addr_memory_o       (addr_memory_o),
        .addr_periph_o       (addr_periph_o),
        .ld_data_o           (ld_data_o),
        .input_periph_data_o (input_periph_data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] ref_ld(input logic [11:0] a);
        int base;
        base = (a >= 12'h800) ? 0 : int'(a);
        return {ref_mem[(base + 3) % 2048], ref_mem[(base + 2) % 2048],
                ref_mem[(base + 1) % 2048], ref_mem[base % 2048]};
    endfunction

    function automatic logic [1:0] ref_sel(input logic [11:0] a);
        int v;
        v = int'(a);
        return {1'(v / 2048), 1'((v / 256) % 2)};
    endfunction

    function automatic logic [10:0] ref_amem(input logic [11:0] a);
        return (int'(a) < 2048) ? 11'(int'(a)) : 11'h000;
    endfunction

    function automatic logic [11:0] ref_aper(input logic [11:0] a);
        return (int'(a) < 2048) ? 12'h000 : a;
    endfunction

    task automatic drive(input logic st, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        st_en_i   = st;
        addr_i    = a;
        st_data_i = d;
        mask_i    = m;
        #1;
    endtask

    // Applies the edge's effect to the model, then advances past the edge.
    task automatic clk_edge();
        logic [31:0] d;
        logic [3:0]  m;
        d = st_data_i;
        m = mask_i;
        if (rst_ni && st_en_i && int'(addr_i) < 2048) begin
            for (int k = 0; k < 4; k++) begin
                if (m[k]) ref_mem[(int'(addr_i) + k) % 2048] = d[8*k +: 8];
            end
        end
        if (rst_ni) ref_sw = io_sw_i;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        io_sw_i = 32'hFFFF_FFFF;
        ref_sw  = 32'h0;
        drive(1'b0, 12'h9A5, 32'h0, 4'h0);
        total++;
        if (input_periph_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_periph: got %h want %h", input_periph_data_o, 32'h0);
        end
        total++;
        if (addr_sel_o !== 2'b11 || addr_periph_o !== 12'h9A5 || addr_memory_o !== 11'h000) begin
            bad++;
            $display("FAIL reset_decode: got sel=%b per=%h mem=%h want 11 9a5 000",
                     addr_sel_o, addr_periph_o, addr_memory_o);
        end
        @(posedge clk_i);
        #1;
        total++;
        if (input_periph_data_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_periph_hold: got %h want 0", input_periph_data_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_fill();
        logic [11:0] a;
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 12'(i * 4), $urandom, 4'hF);
            clk_edge();
        end
        drive(1'b0, 12'h0, 32'h0, 4'h0);
        for (int i = 0; i < 24; i++) begin
            a = 12'($urandom_range(0, 2047));
            drive(1'b0, a, 32'h0, 4'h0);
            total++;
            if (ld_data_o !== ref_ld(a)) begin
                bad++;
                $display("FAIL fill_read @%h: got %h want %h", a, ld_data_o, ref_ld(a));
            end
        end
    endtask

    task automatic test_plan();
        logic [31:0] saved;
        // byte store at 0x001
        drive(1'b1, 12'h001, 32'h1234_8678, 4'b0001);
        clk_edge();
        total++;
        if (ld_data_o[7:0] !== 8'h78 || addr_sel_o !== 2'b00) begin
            bad++;
            $display("FAIL plan_byte: got ld=%h sel=%b want xx..78 sel 00", ld_data_o, addr_sel_o);
        end
        drive(1'b0, 12'h002, 32'h0, 4'h0);
        total++;
        if (ld_data_o !== ref_ld(12'h002)) begin
            bad++;
            $display("FAIL plan_byte_neighbours: got %h want %h", ld_data_o, ref_ld(12'h002));
        end
        // halfword at 0x5AA
        drive(1'b1, 12'h5AA, 32'h1234_8678, 4'b0011);
        clk_edge();
        total++;
        if (addr_sel_o !== 2'b01 || ld_data_o[15:0] !== 16'h8678 || ld_data_o !== ref_ld(12'h5AA)) begin
            bad++;
            $display("FAIL plan_half: got sel=%b ld=%h want 01 %h", addr_sel_o, ld_data_o, ref_ld(12'h5AA));
        end
        // word at 0x004
        drive(1'b1, 12'h004, 32'h1234_8678, 4'b1111);
        clk_edge();
        total++;
        if (ld_data_o !== 32'h1234_8678) begin
            bad++;
            $display("FAIL plan_word: got %h want 12348678", ld_data_o);
        end
        drive(1'b0, 12'h000, 32'h0, 4'h0);
        saved = ld_data_o;
        // store to output peripheral must not touch memory
        drive(1'b1, 12'h800, 32'hDEAD_BEEF, 4'b1111);
        total++;
        if (addr_sel_o !== 2'b10 || addr_periph_o !== 12'h800 || addr_memory_o !== 11'h000) begin
            bad++;
            $display("FAIL plan_out_decode: got sel=%b per=%h mem=%h want 10 800 000",
                     addr_sel_o, addr_periph_o, addr_memory_o);
        end
        clk_edge();
        drive(1'b0, 12'h004, 32'h0, 4'h0);
        total++;
        if (ld_data_o !== 32'h1234_8678) begin
            bad++;
            $display("FAIL plan_out_reread: got %h want 12348678", ld_data_o);
        end
        drive(1'b0, 12'h000, 32'h0, 4'h0);
        total++;
        if (ld_data_o !== saved) begin
            bad++;
            $display("FAIL plan_out_mem0: got %h want %h", ld_data_o, saved);
        end
        // input peripheral
        io_sw_i = 32'h9876_5432;
        drive(1'b1, 12'h900, 32'h5555_AAAA, 4'b1111);
        total++;
        if (addr_sel_o !== 2'b11 || addr_periph_o !== 12'h900) begin
            bad++;
            $display("FAIL plan_in_decode: got sel=%b per=%h want 11 900", addr_sel_o, addr_periph_o);
        end
        clk_edge();
        total++;
        if (input_periph_data_o !== 32'h9876_5432 || ld_data_o !== saved) begin
            bad++;
            $display("FAIL plan_in_sample: got sw=%h ld=%h want 98765432 %h",
                     input_periph_data_o, ld_data_o, saved);
        end
        // wrap-around word at 0x7FE
        drive(1'b1, 12'h7FE, 32'hAABB_CCDD, 4'b1111);
        clk_edge();
        total++;
        if (ld_data_o !== 32'hAABB_CCDD) begin
            bad++;
            $display("FAIL plan_wrap: got %h want aabbccdd", ld_data_o);
        end
        drive(1'b0, 12'h000, 32'h0, 4'h0);
        total++;
        if (ld_data_o[15:0] !== 16'hAABB || ld_data_o !== ref_ld(12'h000)) begin
            bad++;
            $display("FAIL plan_wrap_low: got %h want %h", ld_data_o, ref_ld(12'h000));
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] exp_old;
        for (int i = 0; i < 400; i++) begin
            // Bias towards memory and the wrap corner.
            case ($urandom_range(0, 3))
                0: a = 12'($urandom_range(2040, 2047));
                1: a = 12'($urandom_range(2048, 4095));
                default: a = 12'($urandom_range(0, 2047));
            endcase
            io_sw_i = $urandom;
            drive(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            exp_old = ref_ld(a);
            total++;
            if (addr_sel_o !== ref_sel(a) || addr_memory_o !== ref_amem(a) ||
                addr_periph_o !== ref_aper(a) || ld_data_o !== exp_old) begin
                bad++;
                $display("FAIL rand_pre @%h: got sel=%b mem=%h per=%h ld=%h want %b %h %h %h",
                         a, addr_sel_o, addr_memory_o, addr_periph_o, ld_data_o,
                         ref_sel(a), ref_amem(a), ref_aper(a), exp_old);
            end
            clk_edge();
            total++;
            if (ld_data_o !== ref_ld(a) || input_periph_data_o !== ref_sw) begin
                bad++;
                $display("FAIL rand_post @%h: got ld=%h sw=%h want %h %h",
                         a, ld_data_o, input_periph_data_o, ref_ld(a), ref_sw);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] a;
        for (int i = 0; i < 6; i++) begin
            a = 12'($urandom_range(0, 2047));
            io_sw_i = $urandom;
            drive(1'b1, a, $urandom, 4'hF);
            clk_edge();
            // assert reset between edges
            rst_ni = 1'b0;
            ref_sw = 32'h0;
            #1;
            total++;
            if (input_periph_data_o !== 32'h0) begin
                bad++;
                $display("FAIL mid_reset_async: got %h want 0", input_periph_data_o);
            end
            drive(1'b1, a, ~st_data_i, 4'hF);
            clk_edge();
            total++;
            if (ld_data_o !== ref_ld(a) || input_periph_data_o !== 32'h0) begin
                bad++;
                $display("FAIL mid_reset_blocked @%h: got ld=%h sw=%h want %h 0",
                         a, ld_data_o, input_periph_data_o, ref_ld(a));
            end
            @(negedge clk_i);
            rst_ni  = 1'b1;
            io_sw_i = $urandom;
            drive(1'b1, a, $urandom, 4'b0101);
            clk_edge();
            total++;
            if (ld_data_o !== ref_ld(a) || input_periph_data_o !== ref_sw) begin
                bad++;
                $display("FAIL mid_reset_release @%h: got ld=%h sw=%h want %h %h",
                         a, ld_data_o, input_periph_data_o, ref_ld(a), ref_sw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_plan();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
